core_mem_access: RTL and testbench

Memory-stage access controller for the core pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns a load/store from EX/MEM into a single-outstanding request/response transaction toward the local data memory / ring-network interface. While the transaction is pending it stalls the pipeline, and it presents the load result with `valid_read_memdata` to the MEM/WB register, which captures only when that signal is high.

---
 rtl/core_mem_access.sv | 128 ++++++++++++
 tb/tb_core_mem_access.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_access.sv
// core_mem_access
// Memory-stage access controller. Turns a load/store held in EX/MEM into a
// single outstanding request/response transaction, stalls the pipeline while
// it is pending and hands the load result to MEM/WB.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   mem_read, mem_write      EX/MEM op decode (mutually exclusive)
//   mem_addr, mem_wdata      EX/MEM byte address and store data
//   req_valid/req_ready      request handshake toward memory side
//   req_wr, req_addr,        request fields (word-aligned address),
//   req_wdata                held stable while req_valid is high
//   resp_valid, resp_data    one-cycle response/ack, read data
//   read_memdata             load result to MEM/WB
//   valid_read_memdata       MEM stage result valid (MEM/WB capture enable)
//   mem_stall                pipeline freeze, always ~valid_read_memdata
//   mem_misalign             one-cycle pulse: misaligned access dropped
//   mem_timeout              one-cycle pulse: transaction abandoned
module core_mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wr,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic [31:0] read_memdata,
  output logic        valid_read_memdata,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       op;
  logic       misaligned;
  logic       timeout_hit;

  assign op          = mem_read | mem_write;
  assign misaligned  = (mem_addr[1:0] != 2'b00);
  assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (op) state_nxt = misaligned ? DONE : REQ;
      REQ:       if (req_valid && req_ready) state_nxt = WAIT_RESP;
      WAIT_RESP: if (resp_valid || timeout_hit) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // EX/MEM still shows the completing instruction during DONE, so only the
  // IDLE decode of an op may stall.
  always_comb begin
    valid_read_memdata = (state == DONE) || ((state == IDLE) && !op);
    mem_stall          = !valid_read_memdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      req_valid    <= 1'b0;
      req_wr       <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      read_memdata <= '0;
      mem_misalign <= 1'b0;
      mem_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      mem_misalign <= 1'b0;
      mem_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (op) begin
            if (misaligned) begin
              mem_misalign <= 1'b1;
              if (mem_read) read_memdata <= '0;
            end else begin
              req_addr  <= {mem_addr[31:2], 2'b00};
              req_wdata <= mem_wdata;
              req_wr    <= mem_write;
              req_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            cnt       <= '0;
          end
        end
        WAIT_RESP: begin
          cnt <= cnt + 8'd1;
          // A response arriving on the last allowed cycle still wins.
          if (resp_valid) begin
            if (!req_wr) read_memdata <= resp_data;
          end else if (timeout_hit) begin
            read_memdata <= '0;
            mem_timeout  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_access.sv
module tb_core_mem_access;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] read_memdata;
  logic        valid_read_memdata;
  logic        mem_stall;
  logic        mem_misalign;
  logic        mem_timeout;

  int unsigned checks;
  int unsigned passed;
  logic [31:0] sb[$];
  logic [31:0] exp;

  core_mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .read_memdata(read_memdata), .valid_read_memdata(valid_read_memdata),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    tick(); tick(); sample();
    checks++; if (req_valid !== 1'b0) $display("FAIL reset_req_valid got %h want 0", req_valid); else passed++;
    checks++; if (req_wr !== 1'b0) $display("FAIL reset_req_wr got %h want 0", req_wr); else passed++;
    checks++; if (req_addr !== 32'h0) $display("FAIL reset_req_addr got %h want 0", req_addr); else passed++;
    checks++; if (read_memdata !== 32'h0) $display("FAIL reset_read_memdata got %h want 0", read_memdata); else passed++;
    checks++; if ({mem_misalign, mem_timeout} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {mem_misalign, mem_timeout}); else passed++;
    checks++; if ({valid_read_memdata, mem_stall} !== 2'b10) $display("FAIL reset_valid_stall got %b want 10", {valid_read_memdata, mem_stall}); else passed++;
    tick(); rst = 1'b1; sample();
  endtask

  task automatic test_load();
    tick(); mem_read = 1'b1; mem_addr = 32'h0000_0104; mem_wdata = 32'h0; req_ready = 1'b1;
    sb.push_back(32'hCAFE_F00D);
    sample();
    checks++; if (mem_stall !== 1'b1) $display("FAIL load_c0_stall got %h want 1", mem_stall); else passed++;
    tick(); sample();
    checks++; if (req_valid !== 1'b1) $display("FAIL load_c1_req_valid got %h want 1", req_valid); else passed++;
    checks++; if (req_addr !== 32'h104) $display("FAIL load_c1_req_addr got %h want 00000104", req_addr); else passed++;
    checks++; if (req_wr !== 1'b0) $display("FAIL load_c1_req_wr got %h want 0", req_wr); else passed++;
    checks++; if (mem_stall !== 1'b1) $display("FAIL load_c1_stall got %h want 1", mem_stall); else passed++;
    tick(); resp_valid = 1'b1; resp_data = 32'hCAFE_F00D; sample();
    checks++; if ({mem_stall, req_valid} !== 2'b10) $display("FAIL load_c2_stall_reqv got %b want 10", {mem_stall, req_valid}); else passed++;
    tick(); resp_valid = 1'b0; resp_data = '0; sample();
    exp = sb.pop_front();
    checks++; if (valid_read_memdata !== 1'b1) $display("FAIL load_c3_valid got %h want 1", valid_read_memdata); else passed++;
    checks++; if (read_memdata !== exp) $display("FAIL load_c3_data got %h want %h", read_memdata, exp); else passed++;
    tick(); mem_read = 1'b0; req_ready = 1'b0; sample();
    checks++; if ({valid_read_memdata, mem_stall} !== 2'b10) $display("FAIL load_after_valid got %b want 10", {valid_read_memdata, mem_stall}); else passed++;
  endtask

  task automatic test_store();
    tick(); mem_write = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h1234_5678; req_ready = 1'b0;
    sb.push_back(32'hCAFE_F00D);
    sample();
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) req_ready = 1'b1;
      sample();
      checks++; if (req_valid !== 1'b1) $display("FAIL store_c%0d_req_valid got %h want 1", i, req_valid); else passed++;
      checks++; if (req_wdata !== 32'h1234_5678) $display("FAIL store_c%0d_wdata got %h want 12345678", i, req_wdata); else passed++;
      checks++; if ({req_wr, req_addr} !== {1'b1, 32'h200}) $display("FAIL store_c%0d_wr_addr got %b/%h want 1/00000200", i, req_wr, req_addr); else passed++;
    end
    tick(); req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'hBAD0_BAD0; sample();
    checks++; if (req_valid !== 1'b0) $display("FAIL store_wait_req_valid got %h want 0", req_valid); else passed++;
    tick(); resp_valid = 1'b0; sample();
    exp = sb.pop_front();
    checks++; if (valid_read_memdata !== 1'b1) $display("FAIL store_done_valid got %h want 1", valid_read_memdata); else passed++;
    checks++; if (read_memdata !== exp) $display("FAIL store_read_unchanged got %h want %h", read_memdata, exp); else passed++;
    tick(); mem_write = 1'b0; sample();
  endtask

  task automatic test_timeout();
    // Never answered: WAIT_RESP covers cycles 2..5, DONE with timeout in cycle 6.
    tick(); mem_read = 1'b1; mem_addr = 32'h300; req_ready = 1'b1;
    sb.push_back(32'h0);
    sample();
    tick(); sample();
    for (int c = 2; c <= 5; c++) begin
      tick(); sample();
      checks++; if ({mem_timeout, mem_stall} !== 2'b01) $display("FAIL timeout_c%0d_early got %b want 01", c, {mem_timeout, mem_stall}); else passed++;
    end
    tick(); sample();
    exp = sb.pop_front();
    checks++; if (mem_timeout !== 1'b1) $display("FAIL timeout_pulse got %h want 1", mem_timeout); else passed++;
    checks++; if (read_memdata !== exp) $display("FAIL timeout_data got %h want %h", read_memdata, exp); else passed++;
    checks++; if (valid_read_memdata !== 1'b1) $display("FAIL timeout_valid got %h want 1", valid_read_memdata); else passed++;
    tick(); mem_read = 1'b0; req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF; sample();
    checks++; if ({mem_timeout, valid_read_memdata} !== 2'b01) $display("FAIL timeout_idle got %b want 01", {mem_timeout, valid_read_memdata}); else passed++;
    tick(); resp_valid = 1'b0; sample();
    checks++; if (read_memdata !== 32'h0) $display("FAIL timeout_spurious_resp got %h want 0", read_memdata); else passed++;

    // Response on the final allowed cycle beats the timeout.
    tick(); mem_read = 1'b1; mem_addr = 32'h304; req_ready = 1'b1;
    sb.push_back(32'h5A5A_A5A5);
    sample();
    for (int c = 1; c <= 4; c++) begin
      tick(); sample();
    end
    tick(); resp_valid = 1'b1; resp_data = 32'h5A5A_A5A5; sample();
    tick(); resp_valid = 1'b0; sample();
    exp = sb.pop_front();
    checks++; if ({mem_timeout, valid_read_memdata} !== 2'b01) $display("FAIL resp_wins_flags got %b want 01", {mem_timeout, valid_read_memdata}); else passed++;
    checks++; if (read_memdata !== exp) $display("FAIL resp_wins_data got %h want %h", read_memdata, exp); else passed++;
    tick(); mem_read = 1'b0; req_ready = 1'b0; sample();
  endtask

  task automatic test_misalign();
    tick(); mem_read = 1'b1; mem_addr = 32'h0000_0103; req_ready = 1'b1;
    sb.push_back(32'h0);
    sample();
    checks++; if ({valid_read_memdata, mem_stall} !== 2'b01) $display("FAIL misalign_c0 got %b want 01", {valid_read_memdata, mem_stall}); else passed++;
    tick(); sample();
    exp = sb.pop_front();
    checks++; if (mem_misalign !== 1'b1) $display("FAIL misalign_pulse got %h want 1", mem_misalign); else passed++;
    checks++; if (req_valid !== 1'b0) $display("FAIL misalign_no_req got %h want 0", req_valid); else passed++;
    checks++; if (read_memdata !== exp) $display("FAIL misalign_data got %h want %h", read_memdata, exp); else passed++;
    checks++; if (valid_read_memdata !== 1'b1) $display("FAIL misalign_c1_valid got %h want 1", valid_read_memdata); else passed++;
    tick(); mem_read = 1'b0; req_ready = 1'b0; sample();
    checks++; if ({mem_misalign, req_valid} !== 2'b00) $display("FAIL misalign_c2 got %b want 00", {mem_misalign, req_valid}); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [2];
    logic [31:0] datas [2];
    logic        got;
    logic        pending;
    int unsigned n;
    addrs[0] = 32'h500; datas[0] = 32'h1111_1111;
    addrs[1] = 32'h504; datas[1] = 32'h2222_2222;
    tick(); mem_read = 1'b0; sample();
    checks++; if ({valid_read_memdata, mem_stall} !== 2'b10) $display("FAIL stream_alu0 got %b want 10", {valid_read_memdata, mem_stall}); else passed++;
    for (int i = 0; i < 2; i++) begin
      tick(); mem_read = 1'b1; mem_addr = addrs[i]; req_ready = 1'b1;
      sb.push_back(datas[i]);
      sample();
      checks++; if (mem_stall !== 1'b1) $display("FAIL stream_ld%0d_stall got %h want 1", i, mem_stall); else passed++;
      got = 1'b0; pending = 1'b0; n = 0;
      while (!got && n < 10) begin
        tick(); resp_valid = pending; resp_data = pending ? datas[i] : 32'h0; pending = 1'b0;
        sample(); n++;
        if (req_valid) pending = 1'b1;
        if (valid_read_memdata) got = 1'b1;
      end
      exp = sb.pop_front();
      checks++; if (n !== 3) $display("FAIL stream_ld%0d_latency got %0d want 3", i, n); else passed++;
      checks++; if (read_memdata !== exp) $display("FAIL stream_ld%0d_data got %h want %h", i, read_memdata, exp); else passed++;
    end
    tick(); mem_read = 1'b0; resp_valid = 1'b0; req_ready = 1'b0; sample();
    checks++; if ({valid_read_memdata, mem_stall} !== 2'b10) $display("FAIL stream_alu1 got %b want 10", {valid_read_memdata, mem_stall}); else passed++;
    tick(); sample();
    checks++; if (valid_read_memdata !== 1'b1) $display("FAIL stream_single_done got %h want 1", valid_read_memdata); else passed++;
  endtask

  task automatic test_reset_mid();
    tick(); mem_read = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h1234_5678; req_ready = 1'b1; sample();
    tick(); sample();
    tick(); sample();
    checks++; if ({req_valid, mem_stall} !== 2'b01) $display("FAIL rstmid_wait got %b want 01", {req_valid, mem_stall}); else passed++;
    tick(); rst = 1'b0; sample();
    tick(); rst = 1'b1; mem_read = 1'b0; req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h55AA_55AA; sample();
    checks++; if ({req_valid, req_wr} !== 2'b00) $display("FAIL rstmid_req got %b want 00", {req_valid, req_wr}); else passed++;
    checks++; if (req_addr !== 32'h0) $display("FAIL rstmid_req_addr got %h want 0", req_addr); else passed++;
    checks++; if (req_wdata !== 32'h0) $display("FAIL rstmid_req_wdata got %h want 0", req_wdata); else passed++;
    checks++; if (read_memdata !== 32'h0) $display("FAIL rstmid_read got %h want 0", read_memdata); else passed++;
    checks++; if ({valid_read_memdata, mem_stall} !== 2'b10) $display("FAIL rstmid_alu got %b want 10", {valid_read_memdata, mem_stall}); else passed++;
    tick(); resp_valid = 1'b0; sample();
    checks++; if (read_memdata !== 32'h0) $display("FAIL rstmid_late_resp got %h want 0", read_memdata); else passed++;
    checks++; if ({valid_read_memdata, mem_stall} !== 2'b10) $display("FAIL rstmid_after got %b want 10", {valid_read_memdata, mem_stall}); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
